// File: rtl/uart_mem_master.sv
// Host-side UART memory-access initiator: serialises read/write requests as 8N1 command frames
// and collects the remote reply. Define UART_MEM_MASTER_CHECKSUM_EN to add XOR checksum bytes.
module uart_mem_master #(
    parameter int unsigned CLK_HZ         = 50000000,
    parameter int unsigned BAUD           = 115200,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic        clk_50M,
    input  logic        rst_n,
    input  logic        uart_rx_pin,
    output logic        uart_tx_pin,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_space,
    input  logic [17:0] req_addr,
    input  logic [17:0] req_wdata,
    output logic        rsp_valid,
    output logic [17:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned BAUD_W       = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned TMO_W        = $clog2(TIMEOUT_CYCLES + 1);
`ifdef UART_MEM_MASTER_CHECKSUM_EN
    localparam int unsigned CSUM_BYTES   = 1;
`else
    localparam int unsigned CSUM_BYTES   = 0;
`endif
    localparam int unsigned RD_TX_BYTES  = 4 + CSUM_BYTES;
    localparam int unsigned WR_TX_BYTES  = 7 + CSUM_BYTES;
    localparam int unsigned RD_RX_BYTES  = 3 + CSUM_BYTES;
    localparam int unsigned WR_RX_BYTES  = 1 + CSUM_BYTES;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_TX_BYTE = 2'd1;
    localparam logic [1:0] S_RX_WAIT = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_START = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;
    localparam logic [1:0] R_STOP  = 2'd3;

    // Main transaction state
    logic [1:0]        state_q, state_d;
    logic              wr_q, wr_d;
    logic              space_q, space_d;
    logic [17:0]       addr_q, addr_d;
    logic [17:0]       wdata_q, wdata_d;
    logic              tx_pin_q, tx_pin_d;
    logic [8:0]        tx_shift_q, tx_shift_d;
    logic [3:0]        tx_bit_q, tx_bit_d;
    logic [BAUD_W-1:0] tx_baud_q, tx_baud_d;
    logic [2:0]        tx_idx_q, tx_idx_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [1:0]        rx_cnt_q, rx_cnt_d;
    logic [17:0]       rx_data_q, rx_data_d;
    logic              err_acc_q, err_acc_d;
`ifdef UART_MEM_MASTER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif
    logic              req_ready_q, req_ready_d;
    logic              busy_q, busy_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [17:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    // Receiver state
    logic              rx_meta_q, rx_sync_q, rx_prev_q;
    logic [1:0]        rx_state_q, rx_state_d;
    logic [BAUD_W-1:0] rx_baud_q, rx_baud_d;
    logic [2:0]        rx_bitn_q, rx_bitn_d;
    logic [7:0]        rx_shift_q, rx_shift_d;
    logic              rx_done_c;

    logic [2:0]        tx_last_idx_c;
    logic [2:0]        tx_next_idx_c;
    logic [7:0]        tx_first_c;
    logic [7:0]        tx_next_c;
    logic [1:0]        rx_last_cnt_c;
    logic              rx_bad_c;

    function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                              input logic        wr,
                                              input logic        sp,
                                              input logic [17:0] addr,
                                              input logic [17:0] wdata);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            3'd0:    b = {6'b101000, wr, sp};
            3'd1:    b = addr[7:0];
            3'd2:    b = addr[15:8];
            3'd3:    b = {6'b000000, addr[17:16]};
            3'd4:    b = wdata[7:0];
            3'd5:    b = wdata[15:8];
            3'd6:    b = {6'b000000, wdata[17:16]};
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Byte receiver: edge-triggered start, mid-bit sampling, framing errors dropped silently
    always_comb begin
        rx_state_d = rx_state_q;
        rx_baud_d  = rx_baud_q;
        rx_bitn_d  = rx_bitn_q;
        rx_shift_d = rx_shift_q;
        rx_done_c  = 1'b0;
        case (rx_state_q)
            R_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = R_START;
                    rx_baud_d  = '0;
                end
            end
            R_START: begin
                if (rx_baud_q == BAUD_W'(HALF_BIT - 1)) begin
                    rx_baud_d  = '0;
                    rx_bitn_d  = 3'd0;
                    rx_state_d = rx_sync_q ? R_IDLE : R_DATA;
                end else begin
                    rx_baud_d = BAUD_W'(rx_baud_q + BAUD_W'(1));
                end
            end
            R_DATA: begin
                if (rx_baud_q == BAUD_W'(CLKS_PER_BIT - 1)) begin
                    rx_baud_d  = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bitn_d  = 3'(rx_bitn_q + 3'd1);
                    if (rx_bitn_q == 3'd7) begin
                        rx_state_d = R_STOP;
                    end
                end else begin
                    rx_baud_d = BAUD_W'(rx_baud_q + BAUD_W'(1));
                end
            end
            R_STOP: begin
                if (rx_baud_q == BAUD_W'(CLKS_PER_BIT - 1)) begin
                    rx_baud_d  = '0;
                    rx_state_d = R_IDLE;
                    rx_done_c  = rx_sync_q;
                end else begin
                    rx_baud_d = BAUD_W'(rx_baud_q + BAUD_W'(1));
                end
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    // Transaction FSM: frame transmit, reply collection, response
    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        space_d     = space_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        tx_pin_d    = tx_pin_q;
        tx_shift_d  = tx_shift_q;
        tx_bit_d    = tx_bit_q;
        tx_baud_d   = tx_baud_q;
        tx_idx_d    = tx_idx_q;
        tmo_d       = tmo_q;
        rx_cnt_d    = rx_cnt_q;
        rx_data_d   = rx_data_q;
        err_acc_d   = err_acc_q;
`ifdef UART_MEM_MASTER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        req_ready_d = req_ready_q;
        busy_d      = busy_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rx_bad_c    = 1'b0;

        tx_last_idx_c = wr_q ? 3'(WR_TX_BYTES - 1) : 3'(RD_TX_BYTES - 1);
        rx_last_cnt_c = wr_q ? 2'(WR_RX_BYTES - 1) : 2'(RD_RX_BYTES - 1);
        tx_next_idx_c = 3'(tx_idx_q + 3'd1);
        tx_first_c    = frame_byte(3'd0, req_write, req_space, req_addr, req_wdata);
        tx_next_c     = frame_byte(tx_next_idx_c, wr_q, space_q, addr_q, wdata_q);
`ifdef UART_MEM_MASTER_CHECKSUM_EN
        if (tx_next_idx_c == tx_last_idx_c) begin
            tx_next_c = csum_q;
        end
`endif

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    wr_d        = req_write;
                    space_d     = req_space;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    tx_pin_d    = 1'b0;
                    tx_shift_d  = {1'b1, tx_first_c};
                    tx_bit_d    = 4'd0;
                    tx_baud_d   = '0;
                    tx_idx_d    = 3'd0;
`ifdef UART_MEM_MASTER_CHECKSUM_EN
                    csum_d      = tx_first_c;
`endif
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = S_TX_BYTE;
                end
            end
            S_TX_BYTE: begin
                if (tx_baud_q == BAUD_W'(CLKS_PER_BIT - 1)) begin
                    tx_baud_d = '0;
                    if (tx_bit_q == 4'd9) begin
                        if (tx_idx_q == tx_last_idx_c) begin
                            state_d   = S_RX_WAIT;
                            tmo_d     = '0;
                            rx_cnt_d  = 2'd0;
                            err_acc_d = 1'b0;
`ifdef UART_MEM_MASTER_CHECKSUM_EN
                            csum_d    = 8'h00;
`endif
                        end else begin
                            tx_pin_d   = 1'b0;
                            tx_shift_d = {1'b1, tx_next_c};
                            tx_bit_d   = 4'd0;
                            tx_idx_d   = tx_next_idx_c;
`ifdef UART_MEM_MASTER_CHECKSUM_EN
                            csum_d     = csum_q ^ tx_next_c;
`endif
                        end
                    end else begin
                        tx_pin_d   = tx_shift_q[0];
                        tx_shift_d = {1'b1, tx_shift_q[8:1]};
                        tx_bit_d   = 4'(tx_bit_q + 4'd1);
                    end
                end else begin
                    tx_baud_d = BAUD_W'(tx_baud_q + BAUD_W'(1));
                end
            end
            S_RX_WAIT: begin
                tmo_d = TMO_W'(tmo_q + TMO_W'(1));
                if (rx_done_c) begin
                    if (wr_q) begin
                        rx_bad_c = (rx_shift_q != 8'h55);
                    end else begin
                        case (rx_cnt_q)
                            2'd0:    rx_data_d[7:0]   = rx_shift_q;
                            2'd1:    rx_data_d[15:8]  = rx_shift_q;
                            2'd2:    rx_data_d[17:16] = rx_shift_q[1:0];
`ifdef UART_MEM_MASTER_CHECKSUM_EN
                            default: rx_bad_c = (rx_shift_q != csum_q);
`else
                            default: rx_bad_c = 1'b0;
`endif
                        endcase
`ifdef UART_MEM_MASTER_CHECKSUM_EN
                        if (rx_cnt_q != 2'd3) begin
                            csum_d = csum_q ^ rx_shift_q;
                        end
`endif
                    end
                    rx_cnt_d  = 2'(rx_cnt_q + 2'd1);
                    err_acc_d = err_acc_q | rx_bad_c;
                    if (rx_cnt_q == rx_last_cnt_c) begin
                        state_d     = S_DONE;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = err_acc_q | rx_bad_c;
                        if (!wr_q) begin
                            rsp_rdata_d = rx_data_d;
                        end
                    end
                end
                // Timeout only fires if this cycle did not complete the reply
                if (state_d == S_RX_WAIT && tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = S_DONE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end
            end
            S_DONE: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_q        <= 1'b0;
            space_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            tx_pin_q    <= 1'b1;
            tx_shift_q  <= '1;
            tx_bit_q    <= '0;
            tx_baud_q   <= '0;
            tx_idx_q    <= '0;
            tmo_q       <= '0;
            rx_cnt_q    <= '0;
            rx_data_q   <= '0;
            err_acc_q   <= 1'b0;
`ifdef UART_MEM_MASTER_CHECKSUM_EN
            csum_q      <= '0;
`endif
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= R_IDLE;
            rx_baud_q   <= '0;
            rx_bitn_q   <= '0;
            rx_shift_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            space_q     <= space_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            tx_pin_q    <= tx_pin_d;
            tx_shift_q  <= tx_shift_d;
            tx_bit_q    <= tx_bit_d;
            tx_baud_q   <= tx_baud_d;
            tx_idx_q    <= tx_idx_d;
            tmo_q       <= tmo_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_data_q   <= rx_data_d;
            err_acc_q   <= err_acc_d;
`ifdef UART_MEM_MASTER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rx_meta_q   <= uart_rx_pin;
            rx_sync_q   <= rx_meta_q;
            rx_prev_q   <= rx_sync_q;
            rx_state_q  <= rx_state_d;
            rx_baud_q   <= rx_baud_d;
            rx_bitn_q   <= rx_bitn_d;
            rx_shift_q  <= rx_shift_d;
        end
    end

    assign uart_tx_pin = tx_pin_q;
    assign req_ready   = req_ready_q;
    assign busy        = busy_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;

endmodule

// File: doc/uart_mem_master.md
Name: uart_mem_master

Overview:
- Host-side initiator for the UART memory-access protocol served by uart_controller.
- Accepts single-word read/write requests on a valid/ready port and serialises each as a command frame on 8N1 UART TX.
- Collects the reply on UART RX and returns read data or a write acknowledge.
- Used in loopback/self-test builds to drive a remote uart_controller and its data/code memories, in place of a PC.

Parameters:
- CLK_HZ, 50000000, input clock frequency.
- BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division, 434 at defaults).
- TIMEOUT_CYCLES, 2000000, clocks allowed from end of last TX stop bit to complete reply.

Ports:
- clk_50M  input  1  system clock; one clock domain, all logic on rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- uart_rx_pin  input  1  serial reply from remote; asynchronous, 2-FF synchronised inside
- uart_tx_pin  output  1  serial command to remote; idle high
- req_valid  input  1  request present
- req_ready  output  1  block idle, request accepted when req_valid & req_ready
- req_write  input  1  1 = write, 0 = read
- req_space  input  1  0 = data memory, 1 = code memory
- req_addr  input  18  word address
- req_wdata  input  18  write data (ignored for reads)
- rsp_valid  output  1  one-cycle pulse, transaction finished
- rsp_rdata  output  18  read data, valid with rsp_valid on reads; holds until next rsp_valid
- rsp_err  output  1  valid with rsp_valid: timeout or bad acknowledge
- busy  output  1  transaction in progress (= ~req_ready)

Behaviour:
- Reset values:
  - uart_tx_pin=1, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
  - FSM to IDLE; all counters cleared.
- Reset mid-frame: TX line returns high immediately. A partially sent frame is abandoned; the remote recovers by its own timeout.
- Request capture: on the cycle where req_valid & req_ready, latch write/space/addr/wdata and deassert req_ready the next cycle.
- Frame layout:
  - Command byte = 0xA0 | (req_write<<1) | req_space, giving 0xA0 / 0xA1 / 0xA2 / 0xA3.
  - Then 3 address bytes, LSB first; bits 23:18 sent as 0.
  - Writes only: 3 wdata bytes, LSB first, bits 23:18 = 0.
  - Reads send 4 bytes; writes send 7.
- Reply:
  - Read: 3 bytes, LSB first; rsp_rdata = bits 17:0 and upper 6 bits are ignored.
  - Write: 1 byte, 0x55 = ok; any other value sets rsp_err=1.
- TX: 8N1, LSB first. Start bit, 8 data bits and stop bit each last exactly CLKS_PER_BIT clocks. Next byte's start bit follows the previous stop bit back-to-back.
- RX:
  - Falling edge on the synchronised line starts a byte.
  - Start bit is re-checked at CLKS_PER_BIT/2; if high, the edge is treated as a glitch and ignored.
  - Data is sampled mid-bit.
  - Stop bit = 0 is a framing error: byte discarded, not counted.
  - Bytes arriving in IDLE or TX states are discarded.
- FSM: IDLE -> TX_BYTE (loop over frame bytes) -> RX_WAIT -> DONE -> IDLE.
  - RX_WAIT: counts received bytes and times out at TIMEOUT_CYCLES.
  - DONE: pulses rsp_valid for 1 cycle.
  - req_ready reasserts in the cycle after DONE.
- Timeout: if the reply is incomplete after TIMEOUT_CYCLES, go to DONE with rsp_err=1; rsp_rdata keeps its previous value.
- Latency (read, no timeout): 4 TX bytes + remote turnaround + 3 RX bytes + 1 clock from last RX stop-bit sample to rsp_valid.
- A new request may be accepted in the cycle req_ready is high; the second request's TX start bit begins the following cycle.

Optional Feature:
- Macro: UART_MEM_MASTER_CHECKSUM_EN.
- Defined:
  - Append 1 TX byte = XOR of all preceding frame bytes.
  - Reads expect a 4th reply byte = XOR of the 3 data bytes; writes expect 2 bytes, 0x55 then 0x55.
  - Any mismatch -> rsp_err=1.
- Undefined: frames and replies exactly as above, with no checksum logic synthesised.

Test Plan:
- Read data addr 0x00012, remote model replies 0x34,0x12,0x03 -> TX bytes A0 12 00 00; rsp_valid once, rsp_rdata=0x31234, rsp_err=0.
- Write code addr 0x3FFFF, wdata 0x2AAAA, reply 0x55 -> TX A3 FF FF 03 AA AA 02; rsp_err=0; each bit measured as 434 clocks.
- Write with reply 0x00 -> rsp_valid with rsp_err=1.
- Read with no reply (TIMEOUT_CYCLES=5000 override) -> rsp_err=1 at 5000 clocks after last stop bit; rsp_rdata unchanged.
- Assert rst_n=0 during TX byte 2 -> uart_tx_pin=1 and req_ready=1 immediately; a following read completes normally.
- Reply with a framing error on byte 1, then a valid 3-byte resend -> the bad byte is ignored and rsp_rdata comes from the valid bytes. With UART_MEM_MASTER_CHECKSUM_EN, a wrong checksum byte -> rsp_err=1.
